imem_boot_loader: RTL

Sequences the instruction-memory load port at boot. Takes a byte stream from the host link (e.g. UART RX), packs bytes into 32-bit little-endian words and issues one load strobe per word. Checks the memory's load-complete flag, then releases the core via core_run. Sits between the host byte interface, the instruction memory load port and the core's run/hold control.

---
 rtl/imem_boot_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs host bytes into little-endian words, strobes them into instruction memory,
// then releases the core. Define LOADER_CHECKSUM_EN to require a trailing 32-bit word-sum check.
module imem_boot_loader #(
    parameter int unsigned NUM_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned DONE_WAIT      = 4,
    localparam int unsigned WCW           = $clog2(NUM_WORDS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    output logic           byte_ready,
    output logic           mem_load_en,
    output logic [31:0]    mem_load_inst,
    input  logic           mem_load_done,
    output logic           core_run,
    output logic           busy,
    output logic [WCW-1:0] words_loaded,
    output logic           error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = $clog2(DONE_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDrain,
        StRun,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [23:0]     asm_q, asm_d;
    logic [31:0]     inst_q, inst_d;
    logic [WCW-1:0]  words_q, words_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   drain_q, drain_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
`endif

    logic [31:0]     full_word;
    logic [TW-1:0]   timer_inc;
    logic [DW-1:0]   drain_inc;
    logic            last_byte;
    logic            timeout;
    logic            last_word;

    assign full_word = {byte_data, asm_q};
    assign timer_inc = timer_q + 1'b1;
    assign drain_inc = drain_q + 1'b1;
    assign last_byte = byte_ready && byte_valid && (byte_idx_q == 2'd3);
    assign timeout   = byte_ready && !byte_valid && (timer_inc == TW'(TIMEOUT_CYCLES));
    assign last_word = (words_q == WCW'(NUM_WORDS - 1));

    // Outputs decoded from the current state only.
    always_comb begin
        byte_ready  = 1'b0;
        mem_load_en = 1'b0;
        core_run    = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        case (state_q)
            StCollect: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            StWrite: begin
                mem_load_en = 1'b1;
                busy        = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            StDrain: busy     = 1'b1;
            StRun:   core_run = 1'b1;
            StError: error    = 1'b1;
            default: ;
        endcase
    end

    assign mem_load_inst = inst_q;
    assign words_loaded  = words_q;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        inst_d     = inst_q;
        words_d    = words_q;
        timer_d    = timer_q;
        drain_d    = drain_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        // Byte assembly and the idle timer are shared by COLLECT and CHECK.
        if (byte_ready) begin
            if (byte_valid) begin
                timer_d    = '0;
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0:    asm_d[7:0]   = byte_data;
                    2'd1:    asm_d[15:8]  = byte_data;
                    2'd2:    asm_d[23:16] = byte_data;
                    default: ;
                endcase
            end else begin
                timer_d = timer_inc;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StCollect;
                    byte_idx_d = '0;
                    words_d    = '0;
                    timer_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            StCollect: begin
                if (mem_load_done) begin
                    state_d = StError;
                end else if (last_byte) begin
                    inst_d  = full_word;
                    state_d = StWrite;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StWrite: begin
                words_d = words_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = sum_q + inst_q;
`endif
                drain_d = '0;
                // Done before the last word lands means the memory depth disagrees with ours.
                if (mem_load_done) begin
                    state_d = StError;
                end else if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDrain;
`endif
                end else begin
                    state_d = StCollect;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (last_byte) begin
                    state_d = (full_word == sum_q) ? StDrain : StError;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
`endif
            StDrain: begin
                if (mem_load_done) begin
                    state_d = StRun;
                end else if (drain_inc == DW'(DONE_WAIT)) begin
                    state_d = StError;
                end else begin
                    drain_d = drain_inc;
                end
            end
            StRun:   state_d = StRun;
            // The memory write pointer only rewinds on reset, so the failure is sticky.
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            asm_q      <= '0;
            inst_q     <= '0;
            words_q    <= '0;
            timer_q    <= '0;
            drain_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            inst_q     <= inst_d;
            words_q    <= words_d;
            timer_q    <= timer_d;
            drain_q    <= drain_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule
